// File: rtl/shk_slave_regfile.sv
// shk bus responder backed by REG_NUM 32-bit registers at ADDR_BASE; register 0 is exported as o_reg_ctrl.
// Define SHK_SLAVE_ERR_EN to add o_shk_err and return ERR_DATA on decode errors.
module shk_slave_regfile #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
  parameter int          REG_NUM   = 8,
  parameter int          RESP_LAT  = 2
`ifdef SHK_SLAVE_ERR_EN
  , parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
`endif
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_resetn,
  input  logic        i_shk_valid,
  input  logic        i_shk_msync,
  input  logic [31:0] i_shk_mdata,
  input  logic [31:0] i_shk_maddr,
  output logic        o_shk_ready,
  output logic        o_shk_ssync,
  output logic [31:0] o_shk_sdata,
  output logic [31:0] o_shk_saddr,
  output logic [31:0] o_reg_ctrl
`ifdef SHK_SLAVE_ERR_EN
  , output logic      o_shk_err
`endif
);

  localparam int         IDXW     = $clog2(REG_NUM);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(RESP_LAT - 1);

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic                       wr_q, wr_d;
  logic                       bad_q, bad_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [31:0]                addr_q, addr_d;
  logic [31:0]                data_q, data_d;
  logic [31:0]                sdata_q, sdata_d;
  logic [31:0]                saddr_q, saddr_d;
  logic                       err_q, err_d;
  logic [REG_NUM-1:0][31:0]   regs_q, regs_d;

  logic            accept, in_bad, enter_resp;
  logic [31:0]     off;
  logic [IDXW-1:0] in_idx;
  logic            sel_wr, sel_bad;
  logic [IDXW-1:0] sel_idx;
  logic [31:0]     sel_addr, sel_data, bad_data;

  assign accept = i_shk_valid & ready_q;
  assign off    = i_shk_maddr - ADDR_BASE;
  assign in_bad = (i_shk_maddr < ADDR_BASE) || (off >= 32'(4 * REG_NUM)) ||
                  (i_shk_maddr[1:0] != 2'b00);
  assign in_idx = off[IDXW+1:2];

  // With RESP_LAT=1 the response is built on the accept edge itself, before the latches hold the request.
  always_comb begin
    sel_wr   = (state_q == ST_IDLE) ? i_shk_msync : wr_q;
    sel_bad  = (state_q == ST_IDLE) ? in_bad      : bad_q;
    sel_idx  = (state_q == ST_IDLE) ? in_idx      : idx_q;
    sel_addr = (state_q == ST_IDLE) ? i_shk_maddr : addr_q;
    sel_data = (state_q == ST_IDLE) ? i_shk_mdata : data_q;
`ifdef SHK_SLAVE_ERR_EN
    bad_data = ERR_DATA;
`else
    bad_data = sel_wr ? sel_data : 32'h0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    wr_d       = wr_q;
    bad_d      = bad_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sdata_d    = sdata_q;
    saddr_d    = saddr_q;
    regs_d     = regs_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          wr_d    = i_shk_msync;
          bad_d   = in_bad;
          idx_d   = in_idx;
          addr_d  = i_shk_maddr;
          data_d  = i_shk_mdata;
          cnt_d   = CNT_INIT;
          if (RESP_LAT > 1) state_d = ST_WAIT;
          else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
          if (i_shk_msync && !in_bad) regs_d[in_idx] = i_shk_mdata;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Read data is sampled from the bank on the edge that enters RESP.
    if (enter_resp) begin
      saddr_d = sel_addr;
      if (sel_bad)     sdata_d = bad_data;
      else if (sel_wr) sdata_d = sel_data;
      else             sdata_d = regs_q[sel_idx];
    end
    err_d = enter_resp & sel_bad;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sdata_q <= '0;
      saddr_q <= '0;
      err_q   <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sdata_q <= sdata_d;
      saddr_q <= saddr_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  assign o_shk_ready = ready_q;
  assign o_shk_ssync = (state_q == ST_RESP);
  assign o_shk_sdata = sdata_q;
  assign o_shk_saddr = saddr_q;
  assign o_reg_ctrl  = regs_q[0];
`ifdef SHK_SLAVE_ERR_EN
  assign o_shk_err   = err_q;
`else
  logic unused_err;
  assign unused_err  = err_q;
`endif

endmodule

// File: tb/tb_shk_slave_regfile.sv
// Directed bench for shk_slave_regfile at default parameters (RESP_LAT=2, base 0x1000, 8 regs).
module tb_shk_slave_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        msync = 1'b0;
  logic [31:0] mdata = '0;
  logic [31:0] maddr = '0;
  logic        ready, ssync;
  logic [31:0] sdata, saddr, ctrl;
  logic        err;

  int nvec = 0;
  int nerr = 0;

`ifdef SHK_SLAVE_ERR_EN
  localparam logic [31:0] BAD_RD = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] BAD_RD = 32'h0;
`endif

  shk_slave_regfile dut (
    .i_sys_clk   (clk),
    .i_sys_resetn(rst_n),
    .i_shk_valid (valid),
    .i_shk_msync (msync),
    .i_shk_mdata (mdata),
    .i_shk_maddr (maddr),
    .o_shk_ready (ready),
    .o_shk_ssync (ssync),
    .o_shk_sdata (sdata),
    .o_shk_saddr (saddr),
    .o_reg_ctrl  (ctrl)
`ifdef SHK_SLAVE_ERR_EN
    , .o_shk_err (err)
`endif
  );
`ifndef SHK_SLAVE_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic last_err;

  // One request; returns cycles from accept edge to the negedge that sees ssync (0 = none).
  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] sd, output logic [31:0] sa,
                     output logic [31:0] ctrl_acc);
    int n;
    lat = 0; sd = '0; sa = '0; last_err = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    valid = 1'b1; msync = wr; maddr = a; mdata = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    ctrl_acc = ctrl;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ssync) begin
        lat = i; sd = sdata; sa = saddr; last_err = err;
        break;
      end
    end
  endtask

  int          lat, nacc, nss;
  logic [31:0] sd, sa, ca;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_ssync", 32'(ssync), 32'h0);
    chk("rst_sdata", sdata, 32'h0);
    chk("rst_saddr", saddr, 32'h0);
    chk("rst_ctrl", ctrl, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 32'(ready), 32'h1);

    // Write then read back
    req(1'b1, 32'h0000_1004, 32'hA5A5_0001, lat, sd, sa, ca);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_sdata", sd, 32'hA5A5_0001);
    chk("wr_saddr", sa, 32'h0000_1004);
    req(1'b0, 32'h0000_1004, 32'h0, lat, sd, sa, ca);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_sdata", sd, 32'hA5A5_0001);
    chk("rd_saddr", sa, 32'h0000_1004);
    @(negedge clk);
    chk("hold_ssync", 32'(ssync), 32'h0);
    chk("hold_sdata", sdata, 32'hA5A5_0001);

    // Control register updates on the accept edge
    req(1'b1, 32'h0000_1000, 32'h0000_00FF, lat, sd, sa, ca);
    chk("ctrl_acc", ca, 32'h0000_00FF);
    chk("ctrl_lat", 32'(lat), 32'd2);

    // Valid held high for 10 cycles; junk writes offered while ready=0 must be ignored
    nacc = 0; nss = 0;
    for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      if (c < 10) begin
        valid = 1'b1;
        if (ready) begin
          msync = 1'b0; maddr = 32'h0000_1004; mdata = 32'h0; nacc++;
        end else begin
          msync = 1'b1; maddr = 32'h0000_1004; mdata = 32'h1234_5678;
        end
      end else valid = 1'b0;
      if (ssync) begin
        nss++;
        chk("b2b_sdata", sdata, 32'hA5A5_0001);
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(nacc), 32'd4);
    chk("b2b_ssyncs", 32'(nss), 32'd4);

    // Out of range read, misaligned write
    req(1'b0, 32'h0000_2000, 32'h0, lat, sd, sa, ca);
    chk("oor_rd_lat", 32'(lat), 32'd2);
    chk("oor_rd_sdata", sd, BAD_RD);
    chk("oor_rd_saddr", sa, 32'h0000_2000);
`ifdef SHK_SLAVE_ERR_EN
    chk("oor_rd_err", 32'(last_err), 32'h1);
`endif
    req(1'b1, 32'h0000_1002, 32'h1, lat, sd, sa, ca);
    chk("mis_wr_lat", 32'(lat), 32'd2);
`ifdef SHK_SLAVE_ERR_EN
    chk("mis_wr_sdata", sd, 32'hDEAD_BEEF);
    chk("mis_wr_err", 32'(last_err), 32'h1);
`endif
    chk("mis_wr_ctrl", ctrl, 32'h0000_00FF);
    req(1'b0, 32'h0000_1004, 32'h0, lat, sd, sa, ca);
    chk("keep_r1", sd, 32'hA5A5_0001);
    req(1'b0, 32'h0000_1000, 32'h0, lat, sd, sa, ca);
    chk("keep_r0", sd, 32'h0000_00FF);
    req(1'b0, 32'h0000_101C, 32'h0, lat, sd, sa, ca);
    chk("top_r7", sd, 32'h0);
    chk("top_r7_lat", 32'(lat), 32'd2);

    // Reset one cycle after accepting a read
    for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
    valid = 1'b1; msync = 1'b0; maddr = 32'h0000_1004;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    nss = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ssync) nss++;
      chk("mid_ready", 32'(ready), 32'h0);
    end
    chk("mid_ssync", 32'(nss), 32'h0);
    chk("mid_ctrl", ctrl, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 32'(ready), 32'h1);
    req(1'b0, 32'h0000_1004, 32'h0, lat, sd, sa, ca);
    chk("mid_r1", sd, 32'h0);
    chk("mid_r1_lat", 32'(lat), 32'd2);
    req(1'b0, 32'h0000_1000, 32'h0, lat, sd, sa, ca);
    chk("mid_r0", sd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
